// File: rtl/axi_master_pkg.sv
// Shared types and defaults for the AXI master engine and its reorder buffer.
package axi_master_pkg;

    // Life cycle of one read ID slot in the reorder buffer.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        ISSUED = 2'd1,
        DONE   = 2'd2
    } rob_state_e;

    localparam int DEF_ADDR_WIDTH         = 32;
    localparam int DEF_DATA_WIDTH         = 32;
    localparam int DEF_ID_WIDTH           = 4;
    localparam int DEF_MAX_WR_OUTSTANDING = 8;

    // One ROB entry per read ID.
    function automatic int n_ids(input int id_width);
        return 1 << id_width;
    endfunction

endpackage

// File: rtl/axi_master_rob.sv
// Read reorder buffer: allocates IDs in order, absorbs out-of-order R data,
// and retires entries strictly in allocation order.
module axi_master_rob import axi_master_pkg::*; #(
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_i,
    output logic [ID_WIDTH-1:0]   alloc_id_o,
    output logic                  full_o,
    input  logic                  wb_valid_i,
    input  logic [ID_WIDTH-1:0]   wb_id_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  retire_valid_o,
    output logic [DATA_WIDTH-1:0] retire_data_o,
    input  logic                  retire_ready_i,
    output logic [ID_WIDTH:0]     count_o,
    output logic                  err_o
);

    localparam int NIDS = n_ids(ID_WIDTH);

    rob_state_e            state_q [NIDS];
    rob_state_e            state_d [NIDS];
    logic [DATA_WIDTH-1:0] data_q  [NIDS];
    logic [DATA_WIDTH-1:0] data_d  [NIDS];
    logic [ID_WIDTH-1:0]   alloc_q, alloc_d;
    logic [ID_WIDTH-1:0]   ret_q, ret_d;
    logic [ID_WIDTH:0]     cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  retire;

    assign alloc_id_o     = alloc_q;
    assign full_o         = (state_q[alloc_q] != FREE);
    assign retire_valid_o = (state_q[ret_q] == DONE);
    assign retire_data_o  = data_q[ret_q];
    assign count_o        = cnt_q;
    assign err_o          = err_q;
    assign retire         = retire_valid_o & retire_ready_i;

    // Next-state: alloc, write-back and retire always hit distinct entries
    // (FREE, ISSUED and DONE respectively), so all three can apply together.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        alloc_d = alloc_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (wb_valid_i) begin
            if (state_q[wb_id_i] == ISSUED) begin
                state_d[wb_id_i] = DONE;
                data_d[wb_id_i]  = wb_data_i;
            end else begin
                err_d = 1'b1;
            end
        end
        if (retire) begin
            state_d[ret_q] = FREE;
            ret_d          = ret_q + 1'b1;
        end
        if (alloc_i) begin
            state_d[alloc_q] = ISSUED;
            alloc_d          = alloc_q + 1'b1;
        end
        case ({alloc_i, retire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State register; reset frees every entry and clears stored data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '{default: FREE};
            data_q  <= '{default: '0};
            alloc_q <= '0;
            ret_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            alloc_q <= alloc_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/axi_master.sv
// AXI master engine: turns a read/write command stream into AR/AW/W traffic,
// reorders R data through the ROB and tracks ID-less B responses by count.
module axi_master import axi_master_pkg::*; #(
    parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int ID_WIDTH           = DEF_ID_WIDTH,
    parameter int MAX_WR_OUTSTANDING = DEF_MAX_WR_OUTSTANDING
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic                                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]                     cmd_addr,
    input  logic [DATA_WIDTH-1:0]                     cmd_wdata,
    output logic                                      rsp_valid,
    input  logic                                      rsp_ready,
    output logic [DATA_WIDTH-1:0]                     rsp_data,
    output logic                                      wr_done,
    output logic [ID_WIDTH:0]                         rd_outstanding,
    output logic [$clog2(MAX_WR_OUTSTANDING+1)-1:0]   wr_outstanding,
    output logic                                      err_unexp_rid,
    output logic                                      err_unexp_b,
    output logic [ADDR_WIDTH-1:0]                     araddr,
    output logic [ID_WIDTH-1:0]                       arid,
    output logic                                      arvalid,
    input  logic                                      arready,
    output logic [ADDR_WIDTH-1:0]                     awaddr,
    output logic                                      awvalid,
    input  logic                                      awready,
    output logic [DATA_WIDTH-1:0]                     wdata,
    output logic                                      wvalid,
    input  logic                                      wready,
    input  logic [DATA_WIDTH-1:0]                     rdata,
    input  logic [ID_WIDTH-1:0]                       rid,
    input  logic                                      rvalid,
    output logic                                      rready,
    input  logic                                      bvalid,
    output logic                                      bready
);

    localparam int             WCW  = $clog2(MAX_WR_OUTSTANDING + 1);
    localparam logic [WCW-1:0] WMAX = WCW'(MAX_WR_OUTSTANDING);

    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [ID_WIDTH-1:0]   arid_q, arid_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  arvalid_q, arvalid_d, awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic [WCW-1:0]        wcnt_q, wcnt_d;
    logic                  wr_done_q, wr_done_d;
    logic                  err_b_q, err_b_d;
    logic                  rdy_q;
    logic                  rob_full, rob_err;
    logic [ID_WIDTH-1:0]   rob_alloc_id;
    logic                  rd_can, wr_can, rd_acc, wr_acc, b_hs, b_dec;

    assign araddr         = araddr_q;
    assign arid           = arid_q;
    assign arvalid        = arvalid_q;
    assign awaddr         = awaddr_q;
    assign awvalid        = awvalid_q;
    assign wdata          = wdata_q;
    assign wvalid         = wvalid_q;
    assign wr_outstanding = wcnt_q;
    assign wr_done        = wr_done_q;
    assign err_unexp_b    = err_b_q;
    assign err_unexp_rid  = rob_err;
    assign rready         = rdy_q;
    assign bready         = rdy_q;

    axi_master_rob #(
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rob (
        .clk            (clk),
        .rst_n          (rst_n),
        .alloc_i        (rd_acc),
        .alloc_id_o     (rob_alloc_id),
        .full_o         (rob_full),
        .wb_valid_i     (rvalid & rdy_q),
        .wb_id_i        (rid),
        .wb_data_i      (rdata),
        .retire_valid_o (rsp_valid),
        .retire_data_o  (rsp_data),
        .retire_ready_i (rsp_ready),
        .count_o        (rd_outstanding),
        .err_o          (rob_err)
    );

    // Command arbitration and next-state of the AR/AW/W registers and B counter.
    always_comb begin
        b_hs      = bvalid & rdy_q;
        b_dec     = b_hs & (wcnt_q != '0);
        rd_can    = (!arvalid_q | arready) & !rob_full;
        wr_can    = (!awvalid_q | awready) & (!wvalid_q | wready)
                    & ((wcnt_q < WMAX) | b_hs);
        cmd_ready = cmd_write ? wr_can : rd_can;
        rd_acc    = cmd_valid & cmd_ready & !cmd_write;
        wr_acc    = cmd_valid & cmd_ready & cmd_write;

        araddr_d  = araddr_q;
        arid_d    = arid_q;
        arvalid_d = arvalid_q;
        awaddr_d  = awaddr_q;
        awvalid_d = awvalid_q;
        wdata_d   = wdata_q;
        wvalid_d  = wvalid_q;
        if (rd_acc) begin
            araddr_d  = cmd_addr;
            arid_d    = rob_alloc_id;
            arvalid_d = 1'b1;
        end else if (arready) begin
            arvalid_d = 1'b0;
        end
        if (wr_acc) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
        end else begin
            if (awready) awvalid_d = 1'b0;
            if (wready)  wvalid_d  = 1'b0;
        end
        case ({wr_acc, b_dec})
            2'b10:   wcnt_d = wcnt_q + 1'b1;
            2'b01:   wcnt_d = wcnt_q - 1'b1;
            default: wcnt_d = wcnt_q;
        endcase
        wr_done_d = b_dec;
        err_b_d   = err_b_q | (b_hs & (wcnt_q == '0));
    end

    // Register stage; rready/bready come up one clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr_q  <= '0;
            arid_q    <= '0;
            arvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awvalid_q <= 1'b0;
            wdata_q   <= '0;
            wvalid_q  <= 1'b0;
            wcnt_q    <= '0;
            wr_done_q <= 1'b0;
            err_b_q   <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            araddr_q  <= araddr_d;
            arid_q    <= arid_d;
            arvalid_q <= arvalid_d;
            awaddr_q  <= awaddr_d;
            awvalid_q <= awvalid_d;
            wdata_q   <= wdata_d;
            wvalid_q  <= wvalid_d;
            wcnt_q    <= wcnt_d;
            wr_done_q <= wr_done_d;
            err_b_q   <= err_b_d;
            rdy_q     <= 1'b1;
        end
    end

endmodule
